// File: rtl/rs_bank_ooo.sv
// Reservation-station bank: holds dispatched micro-ops until both sources
// are ready, then issues the oldest ready op on each eligible lane.
module rs_bank_ooo #(
  parameter int RS_DEPTH       = 16,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 3,
  parameter int WB_WIDTH       = 3,
  parameter int PRF_W          = 6,
  parameter int ROB_W          = 5,
  parameter int PAYLOAD_W      = 32,
  localparam int CNT_W         = $clog2(RS_DEPTH + 1),
  localparam int AGE_W         = ROB_W + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pipe_flush,
  input  logic [DISPATCH_WIDTH-1:0]           disp_valid,
  input  logic [DISPATCH_WIDTH*ISSUE_WIDTH-1:0] disp_lane_mask,
  input  logic [DISPATCH_WIDTH*PRF_W-1:0]     disp_src1_prn,
  input  logic [DISPATCH_WIDTH*PRF_W-1:0]     disp_src2_prn,
  input  logic [DISPATCH_WIDTH-1:0]           disp_src1_rdy,
  input  logic [DISPATCH_WIDTH-1:0]           disp_src2_rdy,
  input  logic [DISPATCH_WIDTH*AGE_W-1:0]     disp_age,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload,
  output logic [DISPATCH_WIDTH-1:0]           disp_ready,
  input  logic [WB_WIDTH-1:0]                 wb_valid,
  input  logic [WB_WIDTH*PRF_W-1:0]           wb_prn,
  input  logic [ISSUE_WIDTH-1:0]              iss_ready,
  output logic [ISSUE_WIDTH-1:0]              iss_valid,
  output logic [ISSUE_WIDTH*AGE_W-1:0]        iss_age,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]    iss_payload,
  output logic [CNT_W-1:0]                    rs_free_cnt,
  output logic                                rs_empty
);

  localparam int IDX_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int SLOT_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [RS_DEPTH-1:0]    ent_valid, ent_s1_rdy, ent_s2_rdy;
  logic [PRF_W-1:0]       ent_s1_prn  [RS_DEPTH];
  logic [PRF_W-1:0]       ent_s2_prn  [RS_DEPTH];
  logic [ISSUE_WIDTH-1:0] ent_mask    [RS_DEPTH];
  logic [AGE_W-1:0]       ent_age     [RS_DEPTH];
  logic [PAYLOAD_W-1:0]   ent_payload [RS_DEPTH];
  logic [CNT_W-1:0]       free_cnt;

  logic [DISPATCH_WIDTH-1:0] accept, slot_s1_rdy, slot_s2_rdy;
  logic [RS_DEPTH-1:0]       wr_en, req, fire_ent;
  logic [SLOT_W-1:0]         wr_slot [RS_DEPTH];
  logic [ISSUE_WIDTH-1:0]    sel_found, fire;
  logic [IDX_W-1:0]          sel_idx [ISSUE_WIDTH];
  logic [CNT_W-1:0]          acc_n, fire_n;

  // True when any writeback port broadcasts this physical register.
  function automatic logic wb_hit(input logic [PRF_W-1:0] prn);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++)
      if (wb_valid[k] && wb_prn[k*PRF_W +: PRF_W] == prn) hit = 1'b1;
    return hit;
  endfunction

  // ROB age order: same wrap bit compares indices directly, otherwise inverted.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] < b[ROB_W-1:0];
    else                      return a[ROB_W-1:0] > b[ROB_W-1:0];
  endfunction

  // Thermometer ready from the registered free count, plus writeback bypass per slot.
  always_comb begin
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      disp_ready[s]  = free_cnt > CNT_W'(s);
      slot_s1_rdy[s] = disp_src1_rdy[s] | wb_hit(disp_src1_prn[s*PRF_W +: PRF_W]);
      slot_s2_rdy[s] = disp_src2_rdy[s] | wb_hit(disp_src2_prn[s*PRF_W +: PRF_W]);
    end
  end

  assign accept = disp_valid & disp_ready & {DISPATCH_WIDTH{~pipe_flush}};

  // Accepted slots claim the lowest-index free entries in slot order.
  always_comb begin
    logic placed;
    wr_en = '0;
    for (int e = 0; e < RS_DEPTH; e++) wr_slot[e] = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      placed = 1'b0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (accept[s] && !placed && !ent_valid[e] && !wr_en[e]) begin
          placed     = 1'b1;
          wr_en[e]   = 1'b1;
          wr_slot[e] = SLOT_W'(s);
        end
      end
    end
  end

  assign req = ent_valid & ent_s1_rdy & ent_s2_rdy;

  // Each lane in turn takes the oldest eligible request not claimed by a lower lane.
  always_comb begin
    logic [RS_DEPTH-1:0] picked;
    logic                found;
    logic [IDX_W-1:0]    best;
    picked    = '0;
    sel_found = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      found = 1'b0;
      best  = '0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (req[e] && ent_mask[e][k] && !picked[e] &&
            (!found || older(ent_age[e], ent_age[best]))) begin
          found = 1'b1;
          best  = IDX_W'(e);
        end
      end
      if (found) picked[best] = 1'b1;
      sel_found[k] = found;
      sel_idx[k]   = best;
    end
  end

  assign iss_valid = sel_found & {ISSUE_WIDTH{~pipe_flush}};
  assign fire      = iss_valid & iss_ready;

  // Issue data mux, per-entry free strobes and occupancy deltas.
  always_comb begin
    iss_age     = '0;
    iss_payload = '0;
    fire_ent    = '0;
    acc_n       = '0;
    fire_n      = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      iss_age[k*AGE_W +: AGE_W]             = ent_age[sel_idx[k]];
      iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = ent_payload[sel_idx[k]];
      if (fire[k]) fire_ent[sel_idx[k]] = 1'b1;
      fire_n = fire_n + CNT_W'(fire[k]);
    end
    for (int s = 0; s < DISPATCH_WIDTH; s++) acc_n = acc_n + CNT_W'(accept[s]);
  end

  // Entry valid/ready state and free count; flush dominates dispatch and issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid  <= '0;
      ent_s1_rdy <= '0;
      ent_s2_rdy <= '0;
      free_cnt   <= CNT_W'(RS_DEPTH);
    end else if (pipe_flush) begin
      ent_valid <= '0;
      free_cnt  <= CNT_W'(RS_DEPTH);
    end else begin
      free_cnt <= free_cnt - acc_n + fire_n;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (wr_en[e]) begin
          ent_valid[e]  <= 1'b1;
          ent_s1_rdy[e] <= slot_s1_rdy[wr_slot[e]];
          ent_s2_rdy[e] <= slot_s2_rdy[wr_slot[e]];
        end else if (fire_ent[e]) begin
          ent_valid[e] <= 1'b0;
        end else if (ent_valid[e]) begin
          ent_s1_rdy[e] <= ent_s1_rdy[e] | wb_hit(ent_s1_prn[e]);
          ent_s2_rdy[e] <= ent_s2_rdy[e] | wb_hit(ent_s2_prn[e]);
        end
      end
    end
  end

  // Entry payload fields, only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    for (int e = 0; e < RS_DEPTH; e++) begin
      if (wr_en[e]) begin
        ent_s1_prn[e]  <= disp_src1_prn[int'(wr_slot[e])*PRF_W +: PRF_W];
        ent_s2_prn[e]  <= disp_src2_prn[int'(wr_slot[e])*PRF_W +: PRF_W];
        ent_mask[e]    <= disp_lane_mask[int'(wr_slot[e])*ISSUE_WIDTH +: ISSUE_WIDTH];
        ent_age[e]     <= disp_age[int'(wr_slot[e])*AGE_W +: AGE_W];
        ent_payload[e] <= disp_payload[int'(wr_slot[e])*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign rs_free_cnt = free_cnt;
  assign rs_empty    = (free_cnt == CNT_W'(RS_DEPTH));

endmodule

// File: tb/tb_rs_bank_ooo.sv
// Directed bench for rs_bank_ooo with default parameters.
module tb_rs_bank_ooo;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pipe_flush;
  logic [3:0]   disp_valid;
  logic [11:0]  disp_lane_mask;
  logic [23:0]  disp_src1_prn, disp_src2_prn;
  logic [3:0]   disp_src1_rdy, disp_src2_rdy;
  logic [23:0]  disp_age;
  logic [127:0] disp_payload;
  logic [3:0]   disp_ready;
  logic [2:0]   wb_valid;
  logic [17:0]  wb_prn;
  logic [2:0]   iss_ready;
  logic [2:0]   iss_valid;
  logic [17:0]  iss_age;
  logic [95:0]  iss_payload;
  logic [4:0]   rs_free_cnt;
  logic         rs_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_bank_ooo dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .disp_valid(disp_valid), .disp_lane_mask(disp_lane_mask),
    .disp_src1_prn(disp_src1_prn), .disp_src2_prn(disp_src2_prn),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_age(disp_age), .disp_payload(disp_payload), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_prn(wb_prn),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_age(iss_age),
    .iss_payload(iss_payload), .rs_free_cnt(rs_free_cnt), .rs_empty(rs_empty)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_disp;
    disp_valid     = '0;
    disp_lane_mask = '0;
    disp_src1_prn  = '0;
    disp_src2_prn  = '0;
    disp_src1_rdy  = '0;
    disp_src2_rdy  = '0;
    disp_age       = '0;
    disp_payload   = '0;
  endtask

  task automatic clear_all;
    clear_disp();
    pipe_flush = 1'b0;
    wb_valid   = '0;
    wb_prn     = '0;
    iss_ready  = '0;
  endtask

  task automatic set_slot(input int s, input logic [2:0] mask,
                          input logic [5:0] p1, input logic r1,
                          input logic [5:0] p2, input logic r2,
                          input logic [5:0] age, input logic [31:0] pl);
    disp_valid[s]           = 1'b1;
    disp_lane_mask[s*3 +: 3] = mask;
    disp_src1_prn[s*6 +: 6]  = p1;
    disp_src1_rdy[s]         = r1;
    disp_src2_prn[s*6 +: 6]  = p2;
    disp_src2_rdy[s]         = r2;
    disp_age[s*6 +: 6]       = age;
    disp_payload[s*32 +: 32] = pl;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rs_free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free_cnt got %0d exp 16", rs_free_cnt); end
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", rs_empty); end
    checks++; if (disp_ready !== 4'b1111) begin errors++; $display("FAIL reset_disp_ready got %b exp 1111", disp_ready); end
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL reset_iss_valid got %b exp 000", iss_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_age_order;
    clear_all();
    for (int i = 0; i < 4; i++)
      set_slot(i, 3'b001, 6'd1, 1'b1, 6'd2, 1'b1, 6'(i), 32'(100 + i));
    #1;
    checks++; if (disp_ready !== 4'b1111) begin errors++; $display("FAIL order_disp_ready got %b exp 1111", disp_ready); end
    tick();
    clear_disp();
    iss_ready = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL order_valid[%0d] got %b exp 001", i, iss_valid); end
      checks++; if (iss_age[5:0] !== 6'(i)) begin errors++; $display("FAIL order_age[%0d] got %0d exp %0d", i, iss_age[5:0], i); end
      checks++; if (iss_payload[31:0] !== 32'(100 + i)) begin errors++; $display("FAIL order_payload[%0d] got %0d exp %0d", i, iss_payload[31:0], 100 + i); end
      checks++; if (rs_free_cnt !== 5'(12 + i)) begin errors++; $display("FAIL order_free[%0d] got %0d exp %0d", i, rs_free_cnt, 12 + i); end
      tick();
    end
    checks++; if (rs_free_cnt !== 5'd16) begin errors++; $display("FAIL order_free_end got %0d exp 16", rs_free_cnt); end
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL order_empty_end got %b exp 1", rs_empty); end
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL order_valid_end got %b exp 000", iss_valid); end
  endtask

  task automatic test_wrap;
    clear_all();
    set_slot(0, 3'b010, 6'd1, 1'b1, 6'd2, 1'b1, 6'b100001, 32'hAAAA_0001);
    set_slot(1, 3'b010, 6'd1, 1'b1, 6'd2, 1'b1, 6'b011110, 32'hBBBB_0002);
    iss_ready = 3'b010;
    tick();
    clear_disp();
    #1;
    checks++; if (iss_valid !== 3'b010) begin errors++; $display("FAIL wrap_valid0 got %b exp 010", iss_valid); end
    checks++; if (iss_age[11:6] !== 6'b011110) begin errors++; $display("FAIL wrap_first got %b exp 011110", iss_age[11:6]); end
    checks++; if (iss_payload[63:32] !== 32'hBBBB_0002) begin errors++; $display("FAIL wrap_payload0 got %h exp bbbb0002", iss_payload[63:32]); end
    tick();
    checks++; if (iss_age[11:6] !== 6'b100001 || iss_valid !== 3'b010) begin errors++; $display("FAIL wrap_second got %b/%b exp 100001/010", iss_age[11:6], iss_valid); end
    tick();
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", rs_empty); end
  endtask

  task automatic test_wakeup;
    clear_all();
    iss_ready = 3'b111;
    set_slot(0, 3'b001, 6'd9, 1'b0, 6'd1, 1'b1, 6'd5, 32'h55);
    tick();
    clear_disp();
    #1;
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL wake_wait got %b exp 000", iss_valid); end
    wb_valid = 3'b010;
    wb_prn[11:6] = 6'd9;
    #1;
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL wake_same_cycle got %b exp 000", iss_valid); end
    tick();
    wb_valid = '0;
    #1;
    checks++; if (iss_valid !== 3'b001 || iss_age[5:0] !== 6'd5) begin errors++; $display("FAIL wake_issue got %b/%0d exp 001/5", iss_valid, iss_age[5:0]); end
    tick();
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL wake_empty got %b exp 1", rs_empty); end
    // bypass on slot 2 (hole at slot 1); slot 0 waits on an unrelated tag
    set_slot(0, 3'b001, 6'd10, 1'b0, 6'd1, 1'b1, 6'd6, 32'h66);
    set_slot(2, 3'b001, 6'd3, 1'b1, 6'd9, 1'b0, 6'd7, 32'h77);
    wb_valid = 3'b100;
    wb_prn[17:12] = 6'd9;
    tick();
    clear_disp();
    wb_valid = '0;
    #1;
    checks++; if (iss_valid !== 3'b001 || iss_age[5:0] !== 6'd7) begin errors++; $display("FAIL bypass_issue got %b/%0d exp 001/7", iss_valid, iss_age[5:0]); end
    checks++; if (iss_payload[31:0] !== 32'h77) begin errors++; $display("FAIL bypass_payload got %h exp 77", iss_payload[31:0]); end
    tick();
    checks++; if (iss_valid !== 3'b000 || rs_free_cnt !== 5'd15) begin errors++; $display("FAIL nomatch_wait got %b/%0d exp 000/15", iss_valid, rs_free_cnt); end
    wb_valid = 3'b001;
    wb_prn[5:0] = 6'd10;
    tick();
    wb_valid = '0;
    #1;
    checks++; if (iss_valid !== 3'b001 || iss_age[5:0] !== 6'd6) begin errors++; $display("FAIL late_wake got %b/%0d exp 001/6", iss_valid, iss_age[5:0]); end
    tick();
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL bypass_empty got %b exp 1", rs_empty); end
  endtask

  task automatic test_full;
    clear_all();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 4; s++)
        set_slot(s, 3'b001, 6'(20 + 4*c + s), 1'b0, 6'd1, 1'b1, 6'(4*c + s), 32'(4096 + 4*c + s));
      #1;
      checks++; if (disp_ready !== 4'b1111 || rs_free_cnt !== 5'(16 - 4*c)) begin errors++; $display("FAIL fill_%0d got %b/%0d exp 1111/%0d", c, disp_ready, rs_free_cnt, 16 - 4*c); end
      tick();
    end
    checks++; if (rs_free_cnt !== 5'd0 || disp_ready !== 4'b0000) begin errors++; $display("FAIL full_state got %0d/%b exp 0/0000", rs_free_cnt, disp_ready); end
    checks++; if (rs_empty !== 1'b0 || iss_valid !== 3'b000) begin errors++; $display("FAIL full_flags got %b/%b exp 0/000", rs_empty, iss_valid); end
    wb_valid = 3'b001;
    wb_prn[5:0] = 6'd20;
    tick();
    wb_valid = '0;
    iss_ready = 3'b001;
    #1;
    checks++; if (rs_free_cnt !== 5'd0) begin errors++; $display("FAIL full_refuse got %0d exp 0", rs_free_cnt); end
    checks++; if (iss_valid !== 3'b001 || iss_age[5:0] !== 6'd0 || disp_ready !== 4'b0000) begin errors++; $display("FAIL full_issue got %b/%0d/%b exp 001/0/0000", iss_valid, iss_age[5:0], disp_ready); end
    tick();
    clear_disp();
    #1;
    checks++; if (rs_free_cnt !== 5'd1 || disp_ready !== 4'b0001) begin errors++; $display("FAIL full_free_one got %0d/%b exp 1/0001", rs_free_cnt, disp_ready); end
    pipe_flush = 1'b1;
    tick();
    pipe_flush = 1'b0;
    #1;
    checks++; if (rs_free_cnt !== 5'd16) begin errors++; $display("FAIL full_drain got %0d exp 16", rs_free_cnt); end
  endtask

  task automatic test_backpressure;
    clear_all();
    set_slot(0, 3'b011, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 32'hA3);
    set_slot(1, 3'b011, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 32'hA4);
    iss_ready = 3'b010;
    tick();
    clear_disp();
    #1;
    checks++; if (iss_valid !== 3'b011) begin errors++; $display("FAIL bp_valid got %b exp 011", iss_valid); end
    checks++; if (iss_age[5:0] !== 6'd3 || iss_age[11:6] !== 6'd4) begin errors++; $display("FAIL bp_ages got %0d/%0d exp 3/4", iss_age[5:0], iss_age[11:6]); end
    checks++; if (iss_payload[63:32] !== 32'hA4) begin errors++; $display("FAIL bp_payload1 got %h exp a4", iss_payload[63:32]); end
    tick();
    checks++; if (iss_valid !== 3'b001 || iss_age[5:0] !== 6'd3) begin errors++; $display("FAIL bp_hold got %b/%0d exp 001/3", iss_valid, iss_age[5:0]); end
    checks++; if (rs_free_cnt !== 5'd15) begin errors++; $display("FAIL bp_free got %0d exp 15", rs_free_cnt); end
    iss_ready = 3'b001;
    tick();
    checks++; if (iss_valid !== 3'b000 || rs_free_cnt !== 5'd16) begin errors++; $display("FAIL bp_drain got %b/%0d exp 000/16", iss_valid, rs_free_cnt); end
  endtask

  task automatic test_tie;
    clear_all();
    set_slot(1, 3'b100, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 32'hB1);
    set_slot(3, 3'b100, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9, 32'hB3);
    iss_ready = 3'b100;
    tick();
    clear_disp();
    #1;
    checks++; if (iss_valid !== 3'b100 || iss_payload[95:64] !== 32'hB1) begin errors++; $display("FAIL tie_first got %b/%h exp 100/b1", iss_valid, iss_payload[95:64]); end
    tick();
    checks++; if (iss_valid !== 3'b100 || iss_payload[95:64] !== 32'hB3) begin errors++; $display("FAIL tie_second got %b/%h exp 100/b3", iss_valid, iss_payload[95:64]); end
    tick();
    checks++; if (rs_empty !== 1'b1) begin errors++; $display("FAIL tie_empty got %b exp 1", rs_empty); end
  endtask

  task automatic test_flush;
    clear_all();
    set_slot(0, 3'b001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd1, 32'hC1);
    iss_ready = 3'b111;
    tick();
    clear_disp();
    #1;
    checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL flush_pre got %b exp 001", iss_valid); end
    pipe_flush = 1'b1;
    set_slot(0, 3'b001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd2, 32'hC2);
    set_slot(1, 3'b001, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 32'hC3);
    #1;
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL flush_iss_valid got %b exp 000", iss_valid); end
    tick();
    clear_disp();
    pipe_flush = 1'b0;
    #1;
    checks++; if (rs_free_cnt !== 5'd16 || rs_empty !== 1'b1) begin errors++; $display("FAIL flush_after got %0d/%b exp 16/1", rs_free_cnt, rs_empty); end
    checks++; if (iss_valid !== 3'b000 || disp_ready !== 4'b1111) begin errors++; $display("FAIL flush_after_ctl got %b/%b exp 000/1111", iss_valid, disp_ready); end
  endtask

  task automatic test_async_reset;
    clear_all();
    set_slot(0, 3'b001, 6'd30, 1'b0, 6'd2, 1'b1, 6'd1, 32'hD1);
    set_slot(1, 3'b001, 6'd31, 1'b0, 6'd2, 1'b1, 6'd2, 32'hD2);
    tick();
    clear_disp();
    #1;
    checks++; if (rs_free_cnt !== 5'd14) begin errors++; $display("FAIL areset_pre got %0d exp 14", rs_free_cnt); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rs_free_cnt !== 5'd16 || rs_empty !== 1'b1) begin errors++; $display("FAIL areset_now got %0d/%b exp 16/1", rs_free_cnt, rs_empty); end
    rst_n = 1'b1;
    wb_valid = 3'b011;
    wb_prn[5:0] = 6'd30;
    wb_prn[11:6] = 6'd31;
    iss_ready = 3'b111;
    tick();
    wb_valid = '0;
    #1;
    checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL areset_no_issue got %b exp 000", iss_valid); end
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_wrap();
    test_wakeup();
    test_full();
    test_backpressure();
    test_tie();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
